// File: rtl/bcd_pkg.sv
// Shared types and helpers for the iterative binary-to-BCD converter.
package bcd_pkg;

  localparam int BCD_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ADJUST = 2'd1,
    ST_SHIFT  = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  // Decimal digits needed for the largest magnitude the input can carry.
  function automatic int bcd_min_digits(input int width, input bit is_signed);
    longint unsigned max_v;
    longint unsigned p;
    int n;
    if (is_signed) max_v = 64'd1 << (width - 1);
    else           max_v = (64'd1 << width) - 64'd1;
    n = 1;
    p = 64'd10;
    while (p <= max_v) begin
      n++;
      p = p * 64'd10;
    end
    return n;
  endfunction

endpackage

// File: rtl/bcd_digit_adjust.sv
// Double-dabble digit correction: add 3 to a BCD digit above 4.
module bcd_digit_adjust (
  input  logic [3:0] dig_i,
  output logic [3:0] dig_o
);

  assign dig_o = (dig_i > 4'd4) ? dig_i + 4'd3 : dig_i;

endmodule

// File: rtl/module_bin_to_bcd_iter.sv
// Handshaked iterative double-dabble converter, optional signed input.
module module_bin_to_bcd_iter
  import bcd_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3,
  parameter bit SIGNED = 1'b0
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      start_i,
  input  logic [WIDTH-1:0]          bin_i,
  output logic                      busy_o,
  output logic                      done_o,
  output logic [BCD_W*DIGITS-1:0]   bcd_o,
  output logic                      sign_o
);

  localparam int BW = BCD_W * DIGITS;
  localparam int RW = BW + WIDTH;
  localparam int CW = $clog2(WIDTH + 1);

  if (WIDTH < 2) begin : g_bad_width
    $error("WIDTH must be at least 2");
  end
  if (DIGITS < bcd_min_digits(WIDTH, SIGNED)) begin : g_bad_digits
    $error("DIGITS too small for WIDTH");
  end

  state_e          state_q, state_d;
  logic [RW-1:0]   work_q, work_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            sign_lat_q, sign_lat_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [BW-1:0]   bcd_q, bcd_d;
  logic            sign_q, sign_d;

  logic [BW-1:0]    adj_field;
  logic             neg;
  logic [WIDTH-1:0] mag;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adjust u_adj (
      .dig_i (work_q[WIDTH + g*BCD_W +: BCD_W]),
      .dig_o (adj_field[g*BCD_W +: BCD_W])
    );
  end

  // Negating the most negative value wraps to 2^(WIDTH-1) as unsigned.
  assign neg = SIGNED && bin_i[WIDTH-1];
  assign mag = neg ? (~bin_i + {{(WIDTH-1){1'b0}}, 1'b1}) : bin_i;

  always_comb begin
    state_d    = state_q;
    work_d     = work_q;
    cnt_d      = cnt_q;
    sign_lat_d = sign_lat_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    bcd_d      = bcd_q;
    sign_d     = sign_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          work_d     = {{BW{1'b0}}, mag};
          sign_lat_d = neg;
          cnt_d      = CW'(WIDTH);
          busy_d     = 1'b1;
          state_d    = ST_ADJUST;
        end
      end
      ST_ADJUST: begin
        work_d  = {adj_field, work_q[WIDTH-1:0]};
        state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        work_d  = work_q << 1;
        cnt_d   = cnt_q - CW'(1);
        state_d = (cnt_q == CW'(1)) ? ST_DONE : ST_ADJUST;
      end
      ST_DONE: begin
        bcd_d   = work_q[RW-1:WIDTH];
        sign_d  = sign_lat_q & (|work_q[RW-1:WIDTH]);
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        work_d  = '0;
        cnt_d   = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      work_q     <= '0;
      cnt_q      <= '0;
      sign_lat_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      bcd_q      <= '0;
      sign_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      work_q     <= work_d;
      cnt_q      <= cnt_d;
      sign_lat_q <= sign_lat_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      bcd_q      <= bcd_d;
      sign_q     <= sign_d;
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign bcd_o  = bcd_q;
  assign sign_o = sign_q;

endmodule

// File: doc/module_bin_to_bcd_iter.md
# module_bin_to_bcd_iter

Parametrised, handshaked sequential binary-to-BCD converter using the iterative double-dabble algorithm. It generalises the fixed 4-bit/2-digit converter to any input width and digit count. It adds an optional two's-complement signed mode and a start/busy/done handshake. It feeds the seven-segment and display-formatting paths, converting one value per request.

## Interface

- WIDTH, 8, binary input width; ≥ 2.
- DIGITS, 3, BCD digits produced. Elaboration error unless 10^DIGITS > 2^WIDTH − 1 (unsigned) or 10^DIGITS > 2^(WIDTH−1) (signed).
- SIGNED, 0, 1 = bin_i is two's complement; magnitude converted, sign reported separately.

Ports:
- clk_i  in  1  clock; all state on rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- start_i  in  1  conversion request; sampled only in IDLE.
- bin_i  in  WIDTH  value to convert; sampled on the accepting edge only.
- busy_o  out  1  conversion in progress; reset 0.
- done_o  out  1  one-cycle pulse: bcd_o/sign_o just updated; reset 0.
- bcd_o  out  4*DIGITS  packed BCD result, digit 0 (units) in [3:0]; reset 0; holds until next done_o.
- sign_o  out  1  result negative (SIGNED=1 only; tied 0 otherwise); reset 0.

## Operation

- Working register: DIGITS×4 BCD field above a WIDTH-bit binary field. Shift counter is $clog2(WIDTH+1) bits.
- FSM states: IDLE, ADJUST, SHIFT, DONE.
- IDLE:
  - If start_i=1: load the binary field with bin_i (or |bin_i| when SIGNED and bin_i[WIDTH−1]=1). Clear the BCD field. Latch the sign. Counter ← WIDTH. Go to ADJUST.
  - Otherwise stay in IDLE.
- ADJUST: in one cycle, every BCD digit > 4 gets +3 (4-bit, no carry between digits). Go to SHIFT.
- SHIFT: shift the whole register left 1; counter −1. Go to DONE if the counter was 1, else ADJUST.
- DONE: bcd_o ← BCD field; sign_o ← latched sign (forced 0 if the magnitude is 0); done_o=1 for this cycle. Go to IDLE.
- Magnitude in signed mode: two's-complement negate into a WIDTH-bit unsigned field. −2^(WIDTH−1) yields 2^(WIDTH−1) exactly, with no overflow.
- start_i while busy: ignored, with no queueing; the in-flight conversion is unaffected.
- bin_i changes after acceptance: no effect.
- Reset asserted mid-conversion: immediate return to IDLE. All outputs go to 0; the partial result is discarded.
- Unused/illegal state encoding: recover to IDLE with the register cleared.

## Timing

- Acceptance edge E0: start_i=1 in IDLE. busy_o=1 from after E0.
- Edges E1…E2·WIDTH: alternating ADJUST/SHIFT, WIDTH pairs.
- Edge E2·WIDTH+1 (DONE): bcd_o, sign_o, done_o=1 visible after this edge; busy_o=0 in the same cycle.
- Latency from accepting edge to done_o: 2·WIDTH+1 clocks. WIDTH=8 gives 17.
- Throughput: a new start_i may be accepted in the same cycle done_o is high (FSM already in IDLE). Back-to-back period is 2·WIDTH+2 clocks.
- All outputs are registered; no combinational input-to-output path.

## Structure

- Package bcd_pkg:
  - FSM state localparams (2-bit encoding).
  - Function bcd_min_digits(width, signed), used for the elaboration check.
  - BCD digit width constant (4).
- Sub-module bcd_digit_adjust: combinational, 4-bit in → 4-bit out, +3 when > 4. Instantiated DIGITS times by generate inside ADJUST datapath.
- Everything else lives in a single module.

## Test plan

- WIDTH=8, DIGITS=3, SIGNED=0:
  - bin_i=255, start 1 cycle → done_o exactly 17 clocks after acceptance, bcd_o=0x255.
  - bin_i=0 → bcd_o=0x000.
  - bin_i=99 → bcd_o=0x099.
- WIDTH=8, DIGITS=3, SIGNED=1:
  - bin_i=0x80 → bcd_o=0x128, sign_o=1.
  - bin_i=0xFF → bcd_o=0x001, sign_o=1.
  - bin_i=0x7F → bcd_o=0x127, sign_o=0.
- WIDTH=4, DIGITS=2: exhaustive 0–15 → bcd_o equals decimal (15 → 0x15), latency 9 clocks each.
- Busy rejection: start with 200, re-pulse start_i with 37 at clock 5 → single done_o, bcd_o=0x200, busy_o continuous.
- Back-to-back: start_i asserted in the done_o cycle with 42 after 128 → 0x128 then 0x042, done pulses 18 clocks apart.
- Reset mid-conversion: assert rst_i asynchronously at clock 8 of a 255 conversion → busy_o, done_o, bcd_o, sign_o all 0 immediately. No done_o until a new start; the next conversion of 7 gives 0x007.
